frame_sym_timing_gen: RTL and testbench

- Downstream of the frame-head jitter remover in the tbu.
- Consumes its clean, single-cycle internal frame head and flywheels a full NR timing grid: frame, slot and symbol strobes plus SFN/slot/symbol indices.
- Feeds the PUSCH dim-reduce datapath.
- Tracks alignment of each incoming head against the local grid: realigns on mismatch, and flags loss of lock when heads stop arriving.

---
 rtl/tbu_timing_pkg.sv | 19 +
 rtl/frame_sym_timing_gen_if.sv | 28 ++
 rtl/frame_sym_timing_gen_sym_grid_cnt.sv | 56 +++++
 rtl/frame_sym_timing_gen.sv | 143 ++++++++++++++
 tb/tb_frame_sym_timing_gen.sv | 399 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tbu_timing_pkg.sv
// Shared timing definitions for the tbu frame/slot/symbol grid generator.
// Holds the grid constants, the lock-state encoding and small helpers.
package tbu_timing_pkg;

    localparam int SYM_PER_SLOT     = 14;
    localparam int MISS_MAX_DEFAULT = 3;
    localparam int RESYNC_CNT_W     = 8;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        LOCKED   = 2'd1,
        HOLDOVER = 2'd2
    } tim_state_e;

    function automatic logic [RESYNC_CNT_W-1:0] sat_inc(input logic [RESYNC_CNT_W-1:0] v);
        return (v == {RESYNC_CNT_W{1'b1}}) ? v : v + RESYNC_CNT_W'(1);
    endfunction

endpackage

// File: rtl/frame_sym_timing_gen_if.sv
// Timing-grid output bundle: strobes, indices and lock status sent to the
// PUSCH dim-reduce datapath.
interface frame_sym_timing_gen_if #(
    parameter int SLOT_W = 8,
    parameter int SFN_W  = 10
);
    logic              o_frame_head;
    logic              o_slot_head;
    logic              o_sym_head;
    logic [3:0]        o_sym_idx;
    logic [SLOT_W-1:0] o_slot_idx;
    logic [SFN_W-1:0]  o_sfn;
    logic              o_locked;
    logic              o_resync;
    logic [7:0]        o_resync_cnt;

    modport master (
        output o_frame_head, o_slot_head, o_sym_head,
        output o_sym_idx, o_slot_idx, o_sfn,
        output o_locked, o_resync, o_resync_cnt
    );

    modport slave (
        input o_frame_head, o_slot_head, o_sym_head,
        input o_sym_idx, o_slot_idx, o_sfn,
        input o_locked, o_resync, o_resync_cnt
    );
endinterface

// File: rtl/frame_sym_timing_gen_sym_grid_cnt.sv
// Sample/symbol/slot counters of the NR grid. Counts while enabled, can be
// forced to (0,0,0), and flags the terminal cycle of a symbol, slot and frame.
module sym_grid_cnt
    import tbu_timing_pkg::*;
#(
    parameter int CNT_W  = 16,
    parameter int SLOT_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              load_zero,
    input  logic [CNT_W-1:0]  sym_len_long,
    input  logic [CNT_W-1:0]  sym_len_norm,
    input  logic [SLOT_W-1:0] slots_per_frame,
    output logic [3:0]        sym_idx,
    output logic [SLOT_W-1:0] slot_idx,
    output logic              sym_end,
    output logic              slot_end,
    output logic              frame_end
);

    localparam logic [3:0] LAST_SYM = 4'(SYM_PER_SLOT - 1);

    logic [CNT_W-1:0] sample_cnt;
    logic [CNT_W-1:0] sym_len;

    always_comb begin
        sym_len   = (sym_idx == 4'd0) ? sym_len_long : sym_len_norm;
        sym_end   = (sample_cnt == sym_len - CNT_W'(1));
        slot_end  = sym_end && (sym_idx == LAST_SYM);
        frame_end = slot_end && (slot_idx == slots_per_frame - SLOT_W'(1));
    end

    // NOTE: counters are sequential state, so only non-blocking assignments here.
    always_ff @(posedge clk) begin
        if (rst || load_zero) begin
            sample_cnt <= '0;
            sym_idx    <= '0;
            slot_idx   <= '0;
        end else if (en) begin
            if (sym_end) begin
                sample_cnt <= '0;
                if (slot_end) begin
                    sym_idx  <= '0;
                    slot_idx <= frame_end ? '0 : slot_idx + SLOT_W'(1);
                end else begin
                    sym_idx <= sym_idx + 4'd1;
                end
            end else begin
                sample_cnt <= sample_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/frame_sym_timing_gen.sv
// Flywheel NR timing generator: locks to the clean internal frame head,
// realigns on off-grid heads and drops to holdover when heads stop arriving.
module frame_sym_timing_gen
    import tbu_timing_pkg::*;
#(
    parameter int CNT_W    = 16,
    parameter int SLOT_W   = 8,
    parameter int SFN_W    = 10,
    parameter int MISS_MAX = MISS_MAX_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_int_head,
    input  logic [CNT_W-1:0]       i_sym_len_long,
    input  logic [CNT_W-1:0]       i_sym_len_norm,
    input  logic [SLOT_W-1:0]      i_slots_per_frame,
    frame_sym_timing_gen_if.master tim
);

    localparam int                MISS_W    = $clog2(MISS_MAX + 1);
    localparam logic [MISS_W-1:0] MISS_LAST = MISS_W'(MISS_MAX - 1);
    localparam logic [MISS_W-1:0] MISS_TOP  = MISS_W'(MISS_MAX);

    tim_state_e state, state_next;

    logic [CNT_W-1:0]        long_sh, norm_sh;
    logic [SLOT_W-1:0]       slots_sh;
    logic [MISS_W-1:0]       miss_cnt, miss_next;
    logic [SFN_W-1:0]        sfn_q;
    logic [RESYNC_CNT_W-1:0] resync_cnt_q;
    logic                    frame_head_q, slot_head_q, sym_head_q;
    logic                    locked_q, resync_q;

    logic                    running;
    logic                    accept, frame_start, resync_evt;
    logic                    slot_strobe, sym_strobe;
    logic [3:0]              sym_idx;
    logic [SLOT_W-1:0]       slot_idx;
    logic                    sym_end, slot_end, frame_end;

    assign running = (state != IDLE);

    sym_grid_cnt #(
        .CNT_W  (CNT_W),
        .SLOT_W (SLOT_W)
    ) u_grid (
        .clk             (clk),
        .rst             (rst),
        .en              (running),
        .load_zero       (accept),
        .sym_len_long    (long_sh),
        .sym_len_norm    (norm_sh),
        .slots_per_frame (slots_sh),
        .sym_idx         (sym_idx),
        .slot_idx        (slot_idx),
        .sym_end         (sym_end),
        .slot_end        (slot_end),
        .frame_end       (frame_end)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // NOTE: every output of this block gets a default first so no path infers a latch.
    always_comb begin
        state_next  = state;
        miss_next   = miss_cnt;
        accept      = 1'b0;
        frame_start = 1'b0;
        resync_evt  = 1'b0;
        case (state)
            IDLE: begin
                if (i_int_head) begin
                    state_next  = LOCKED;
                    accept      = 1'b1;
                    frame_start = 1'b1;
                    miss_next   = '0;
                end
            end
            LOCKED, HOLDOVER: begin
                if (i_int_head) begin
                    // A head in the natural wrap cycle is on-grid and never counts as a resync.
                    state_next  = LOCKED;
                    accept      = 1'b1;
                    frame_start = 1'b1;
                    resync_evt  = !frame_end;
                    miss_next   = '0;
                end else if (frame_end) begin
                    frame_start = 1'b1;
                    if (miss_cnt != MISS_TOP) miss_next = miss_cnt + MISS_W'(1);
                    if (miss_cnt >= MISS_LAST) state_next = HOLDOVER;
                end
            end
            default: state_next = IDLE;
        endcase
        slot_strobe = frame_start || (running && slot_end);
        sym_strobe  = frame_start || (running && sym_end);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            long_sh      <= '0;
            norm_sh      <= '0;
            slots_sh     <= '0;
            miss_cnt     <= '0;
            sfn_q        <= '0;
            resync_cnt_q <= '0;
            frame_head_q <= 1'b0;
            slot_head_q  <= 1'b0;
            sym_head_q   <= 1'b0;
            locked_q     <= 1'b0;
            resync_q     <= 1'b0;
        end else begin
            if (frame_start) begin
                long_sh  <= i_sym_len_long;
                norm_sh  <= i_sym_len_norm;
                slots_sh <= i_slots_per_frame;
                // The first lock out of IDLE defines frame 0 rather than advancing it.
                sfn_q    <= (state == IDLE) ? '0 : sfn_q + SFN_W'(1);
            end
            if (resync_evt) resync_cnt_q <= sat_inc(resync_cnt_q);
            miss_cnt     <= miss_next;
            frame_head_q <= frame_start;
            slot_head_q  <= slot_strobe;
            sym_head_q   <= sym_strobe;
            locked_q     <= (state == LOCKED);
            resync_q     <= resync_evt;
        end
    end

    assign tim.o_frame_head = frame_head_q;
    assign tim.o_slot_head  = slot_head_q;
    assign tim.o_sym_head   = sym_head_q;
    assign tim.o_sym_idx    = sym_idx;
    assign tim.o_slot_idx   = slot_idx;
    assign tim.o_sfn        = sfn_q;
    assign tim.o_locked     = locked_q;
    assign tim.o_resync     = resync_q;
    assign tim.o_resync_cnt = resync_cnt_q;

endmodule

// File: tb/tb_frame_sym_timing_gen.sv
// Self-checking bench for frame_sym_timing_gen: a frame-position model
// predicts every output each cycle, plus directed timing checks per scenario.
module tb_frame_sym_timing_gen;

    localparam int CNT_W    = 16;
    localparam int SLOT_W   = 8;
    localparam int SFN_W    = 10;
    localparam int MISS_MAX = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic              i_int_head;
    logic [CNT_W-1:0]  cfg_long;
    logic [CNT_W-1:0]  cfg_norm;
    logic [SLOT_W-1:0] cfg_slots;

    always #5 clk = ~clk;

    frame_sym_timing_gen_if #(.SLOT_W(SLOT_W), .SFN_W(SFN_W)) tim ();

    frame_sym_timing_gen #(
        .CNT_W    (CNT_W),
        .SLOT_W   (SLOT_W),
        .SFN_W    (SFN_W),
        .MISS_MAX (MISS_MAX)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .i_int_head        (i_int_head),
        .i_sym_len_long    (cfg_long),
        .i_sym_len_norm    (cfg_norm),
        .i_slots_per_frame (cfg_slots),
        .tim               (tim)
    );

    typedef struct packed {
        logic       fh;
        logic       slh;
        logic       syh;
        logic [3:0] sym;
        logic [7:0] slot;
        logic [9:0] sfn;
        logic       locked;
        logic       resync;
        logic [7:0] rcnt;
    } obs_t;

    obs_t obs;
    obs_t exp_obs = '0;

    assign obs = {tim.o_frame_head, tim.o_slot_head, tim.o_sym_head, tim.o_sym_idx,
                  tim.o_slot_idx, tim.o_sfn, tim.o_locked, tim.o_resync, tim.o_resync_cnt};

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Model: mode 0=idle 1=locked 2=holdover; m_p = clocks since the current frame began.
    int m_mode = 0, m_p = 0, m_long = 0, m_norm = 0, m_slots = 0;
    int m_sfn = 0, m_miss = 0, m_rcnt = 0;

    function automatic int m_flen();
        return m_slots * (m_long + 13 * m_norm);
    endfunction

    function automatic bit m_on_grid();
        return (m_mode != 0) && (m_p == m_flen() - 1);
    endfunction

    task automatic model_step(input logic head, input logic r);
        bit was_locked;
        bit res;
        int flen, slen, rr, sym;
        if (r) begin
            m_mode = 0; m_p = 0; m_sfn = 0; m_miss = 0; m_rcnt = 0;
            m_long = 0; m_norm = 0; m_slots = 0;
            exp_obs = '0;
            return;
        end
        was_locked = (m_mode == 1);
        res  = 1'b0;
        flen = m_flen();
        if (m_mode == 0) begin
            if (head) begin
                m_mode = 1; m_p = 0; m_sfn = 0; m_miss = 0;
                m_long = cfg_long; m_norm = cfg_norm; m_slots = cfg_slots;
            end
        end else if (head) begin
            res = (m_p != flen - 1);
            if (res && m_rcnt < 255) m_rcnt++;
            m_mode = 1; m_p = 0; m_sfn = (m_sfn + 1) % 1024; m_miss = 0;
            m_long = cfg_long; m_norm = cfg_norm; m_slots = cfg_slots;
        end else if (m_p == flen - 1) begin
            m_p = 0; m_sfn = (m_sfn + 1) % 1024;
            m_long = cfg_long; m_norm = cfg_norm; m_slots = cfg_slots;
            if (m_miss < MISS_MAX) m_miss++;
            if (m_miss >= MISS_MAX) m_mode = 2;
        end else begin
            m_p++;
        end
        exp_obs = '0;
        if (m_mode != 0) begin
            slen = m_long + 13 * m_norm;
            rr   = m_p % slen;
            sym  = (rr < m_long) ? 0 : 1 + (rr - m_long) / m_norm;
            exp_obs.fh   = (m_p == 0);
            exp_obs.slh  = (rr == 0);
            exp_obs.syh  = (rr == 0) || (rr >= m_long && ((rr - m_long) % m_norm) == 0);
            exp_obs.sym  = 4'(sym);
            exp_obs.slot = 8'(m_p / slen);
        end
        exp_obs.sfn    = 10'(m_sfn);
        exp_obs.locked = was_locked;
        exp_obs.resync = res;
        exp_obs.rcnt   = 8'(m_rcnt);
    endtask

    // Drives one cycle of inputs, lets the edge happen, and leaves time at the next negedge.
    task automatic tick(input logic head, input logic r);
        i_int_head = head;
        rst        = r;
        @(posedge clk);
        model_step(head, r);
        cyc++;
        @(negedge clk);
    endtask

    task automatic test_reset();
        cfg_long = 16'd8; cfg_norm = 16'd6; cfg_slots = 8'd2;
        for (int i = 0; i < 3; i++) begin
            tick(1'($urandom_range(0, 1)), 1'b1);
            checks++;
            if (obs !== '0) begin
                failures++;
                $display("FAIL reset_zero cyc=%0d got=%h exp=0", cyc, obs);
            end
            checks++;
            if (obs !== exp_obs) begin
                failures++;
                $display("FAIL reset_model cyc=%0d got=%h exp=%h", cyc, obs, exp_obs);
            end
        end
    endtask

    task automatic test_basic_lock();
        for (int i = 0; i < 9; i++) begin
            tick(1'b0, 1'b0);
            checks++;
            if (obs !== exp_obs) begin
                failures++;
                $display("FAIL idle cyc=%0d got=%h exp=%h", cyc, obs, exp_obs);
            end
        end
        tick(1'b1, 1'b0);
        checks++;
        if (obs.fh !== 1'b1 || obs.slh !== 1'b1 || obs.syh !== 1'b1 || obs.sfn !== 10'd0 || obs.locked !== 1'b0) begin
            failures++;
            $display("FAIL lock_first_frame cyc=%0d got=%h", cyc, obs);
        end
        for (int k = 1; k <= 171; k++) begin
            tick(1'b0, 1'b0);
            checks++;
            if (obs !== exp_obs) begin
                failures++;
                $display("FAIL basic_lock cyc=%0d got=%h exp=%h", cyc, obs, exp_obs);
            end
            if (k == 1 || k == 7 || k == 8 || k == 14 || k == 86) begin
                checks++;
                if ((k == 1 && obs.locked !== 1'b1) || (k == 7 && obs.syh !== 1'b0) ||
                    (k == 8 && (obs.syh !== 1'b1 || obs.sym !== 4'd1)) ||
                    (k == 14 && (obs.syh !== 1'b1 || obs.sym !== 4'd2)) ||
                    (k == 86 && (obs.slh !== 1'b1 || obs.slot !== 8'd1 || obs.sym !== 4'd0))) begin
                    failures++;
                    $display("FAIL basic_offset k=%0d got=%h", k, obs);
                end
            end
        end
    endtask

    task automatic test_on_grid();
        int last = -1;
        int n_fh = 0;
        for (int i = 0; i < 516; i++) begin
            tick(1'(m_on_grid()), 1'b0);
            checks++;
            if (obs !== exp_obs) begin
                failures++;
                $display("FAIL on_grid cyc=%0d got=%h exp=%h", cyc, obs, exp_obs);
            end
            if (obs.fh) begin
                n_fh++;
                checks++;
                if (obs.sfn !== 10'(n_fh) || (last >= 0 && cyc - last != 172)) begin
                    failures++;
                    $display("FAIL on_grid_period sfn=%0d want=%0d gap=%0d want=172", obs.sfn, n_fh, cyc - last);
                end
                last = cyc;
            end
        end
        checks++;
        if (n_fh != 3 || obs.rcnt !== 8'd0 || obs.locked !== 1'b1) begin
            failures++;
            $display("FAIL on_grid_summary frames=%0d want=3 rcnt=%0d locked=%b", n_fh, obs.rcnt, obs.locked);
        end
    endtask

    task automatic test_off_grid();
        int sfn_before;
        for (int i = 0; i < 400 && m_p != m_flen() - 6; i++) begin
            tick(1'(m_on_grid()), 1'b0);
            checks++;
            if (obs !== exp_obs) begin
                failures++;
                $display("FAIL off_grid_pre cyc=%0d got=%h exp=%h", cyc, obs, exp_obs);
            end
        end
        sfn_before = m_sfn;
        tick(1'b1, 1'b0);
        checks++;
        if (obs.resync !== 1'b1 || obs.rcnt !== 8'd1 || obs.fh !== 1'b1 || obs.sfn !== 10'(sfn_before + 1)) begin
            failures++;
            $display("FAIL off_grid_resync got=%h want resync=1 rcnt=1 fh=1 sfn=%0d", obs, sfn_before + 1);
        end
        checks++;
        if (obs !== exp_obs) begin
            failures++;
            $display("FAIL off_grid_model cyc=%0d got=%h exp=%h", cyc, obs, exp_obs);
        end
        tick(1'b0, 1'b0);
        checks++;
        if (obs.resync !== 1'b0 || obs.rcnt !== 8'd1 || obs.sym !== 4'd0 || obs.syh !== 1'b0) begin
            failures++;
            $display("FAIL off_grid_pulse got=%h want resync=0 rcnt=1", obs);
        end
    endtask

    task automatic test_holdover();
        int last = -1;
        int n_fh = 0;
        for (int i = 0; i < 1000 && n_fh < 4; i++) begin
            tick(1'b0, 1'b0);
            checks++;
            if (obs !== exp_obs) begin
                failures++;
                $display("FAIL holdover cyc=%0d got=%h exp=%h", cyc, obs, exp_obs);
            end
            if (obs.fh) begin
                n_fh++;
                checks++;
                if ((last >= 0 && cyc - last != 172) || obs.locked !== (n_fh <= 3)) begin
                    failures++;
                    $display("FAIL holdover_frame n=%0d gap=%0d want=172 locked=%b", n_fh, cyc - last, obs.locked);
                end
                last = cyc;
            end
            if (n_fh >= 3 && !obs.fh) begin
                checks++;
                if (obs.locked !== 1'b0) begin
                    failures++;
                    $display("FAIL holdover_unlock cyc=%0d locked=%b want=0", cyc, obs.locked);
                end
            end
        end
        if (n_fh < 4) begin
            failures++;
            $display("FAIL holdover_timeout frames=%0d want=4", n_fh);
        end
        for (int i = 0; i < 400 && !m_on_grid(); i++) tick(1'b0, 1'b0);
        tick(1'b1, 1'b0);
        checks++;
        if (obs.fh !== 1'b1 || obs.resync !== 1'b0 || obs.rcnt !== 8'd1) begin
            failures++;
            $display("FAIL relock_head got=%h want fh=1 resync=0 rcnt=1", obs);
        end
        tick(1'b0, 1'b0);
        checks++;
        if (obs.locked !== 1'b1) begin
            failures++;
            $display("FAIL relock_locked got=%b want=1", obs.locked);
        end
    endtask

    task automatic test_config_shadow();
        int fhs[$];
        int since = -1;
        for (int i = 0; i < 1200 && fhs.size() < 3; i++) begin
            tick(1'(m_on_grid()), 1'b0);
            checks++;
            if (obs !== exp_obs) begin
                failures++;
                $display("FAIL cfg_shadow cyc=%0d got=%h exp=%h", cyc, obs, exp_obs);
            end
            if (obs.fh) fhs.push_back(cyc);
            if (fhs.size() == 1) begin
                since++;
                if (since == 50) cfg_norm = 16'd10;
            end
        end
        checks++;
        if (fhs.size() != 3) begin
            failures++;
            $display("FAIL cfg_shadow_timeout frames=%0d want=3", fhs.size());
        end else if (fhs[1] - fhs[0] != 172 || fhs[2] - fhs[1] != 276) begin
            failures++;
            $display("FAIL cfg_shadow_period got=%0d,%0d want=172,276", fhs[1] - fhs[0], fhs[2] - fhs[1]);
        end
    endtask

    task automatic test_random();
        logic h, r;
        for (int i = 0; i < 6000; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                cfg_long  = 16'($urandom_range(2, 5));
                cfg_norm  = 16'($urandom_range(2, 4));
                cfg_slots = 8'($urandom_range(1, 3));
            end
            r = ($urandom_range(0, 2999) == 0);
            if (m_mode == 0)      h = ($urandom_range(0, 19) == 0);
            else if (m_on_grid()) h = ($urandom_range(0, 3) != 0);
            else                  h = ($urandom_range(0, 149) == 0);
            tick(h, r);
            checks++;
            if (obs !== exp_obs) begin
                failures++;
                $display("FAIL random cyc=%0d got=%h exp=%h", cyc, obs, exp_obs);
            end
        end
    endtask

    task automatic test_sfn_wrap();
        bit seen_max = 1'b0;
        bit done     = 1'b0;
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b1);
        cfg_long = 16'd2; cfg_norm = 16'd2; cfg_slots = 8'd1;
        tick(1'b1, 1'b0);
        for (int i = 0; i < 40000 && !done; i++) begin
            tick(1'b0, 1'b0);
            checks++;
            if (obs !== exp_obs) begin
                failures++;
                $display("FAIL sfn_flywheel cyc=%0d got=%h exp=%h", cyc, obs, exp_obs);
            end
            if (obs.fh) begin
                if (seen_max) begin
                    checks++;
                    if (obs.sfn !== 10'd0) begin
                        failures++;
                        $display("FAIL sfn_wrap got=%0d want=0", obs.sfn);
                    end
                    done = 1'b1;
                end else if (m_sfn == 1023) begin
                    seen_max = 1'b1;
                end
            end
        end
        if (!done) begin
            failures++;
            $display("FAIL sfn_wrap_timeout seen_max=%b", seen_max);
        end
        for (int i = 0; i < 100 && m_p != 10; i++) tick(1'b0, 1'b0);
        tick(1'b1, 1'b1);
        checks++;
        if (obs !== '0) begin
            failures++;
            $display("FAIL midrun_reset got=%h want=0", obs);
        end
        for (int i = 0; i < 5; i++) begin
            tick(1'b0, 1'b0);
            checks++;
            if (obs.fh !== 1'b0 || obs.slh !== 1'b0 || obs.syh !== 1'b0 || obs.locked !== 1'b0 || obs !== exp_obs) begin
                failures++;
                $display("FAIL post_reset_idle cyc=%0d got=%h exp=%h", cyc, obs, exp_obs);
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit reached at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        i_int_head = 1'b0;
        rst        = 1'b1;
        test_reset();
        test_basic_lock();
        test_on_grid();
        test_off_grid();
        test_holdover();
        test_config_shadow();
        test_random();
        test_sfn_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
